// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: opcodes, encoding formats,
// immediate range limits and the opcode-to-format helper.
package rv32i_instr_encoder_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        fmt_r, fmt_i, fmt_ishift, fmt_s, fmt_b, fmt_u, fmt_j, fmt_bad
    } enc_fmt_t;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX = 32'sd4095;
    localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM21_MAX = 32'sd1048575;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    function automatic logic imm_fits(input logic [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

    // Shift-immediates (sll/sr) share the OP-IMM opcode but use their own layout.
    function automatic enc_fmt_t fmt_of(input logic [6:0] op, input logic [2:0] f3);
        enc_fmt_t f;
        f = fmt_bad;
        case (op)
            OP_LUI, OP_AUIPC:   f = fmt_u;
            OP_JAL:             f = fmt_j;
            OP_JALR, OP_LOAD:   f = fmt_i;
            OP_BR:              f = fmt_b;
            OP_STORE:           f = fmt_s;
            OP_IMM:             f = (f3 == 3'b001 || f3 == 3'b101) ? fmt_ishift : fmt_i;
            OP_REG:             f = fmt_r;
            default:            f = fmt_bad;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Field-bundle input and encoded-word output of the RV32I encoder.
// With RV32I_INSTR_ENC_PC_EN defined an out_pc tag travels with each word.
interface rv32i_instr_encoder_if;
    import rv32i_instr_encoder_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_variant;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    instr_t      out_instr;
    logic        err;
    logic [15:0] err_count;
`ifdef RV32I_INSTR_ENC_PC_EN
    logic [31:0] out_pc;
`endif

    modport master (
        output in_valid, in_opcode, in_funct3, in_variant, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, err, err_count
`ifdef RV32I_INSTR_ENC_PC_EN
        , input out_pc
`endif
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_variant, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, err, err_count
`ifdef RV32I_INSTR_ENC_PC_EN
        , output out_pc
`endif
    );

endinterface

// File: rtl/instr_enc_fifo.sv
// Synchronous valid/ready FIFO; DEPTH must be a power of two (>= 2).
// Push is refused while full even if a pop happens in the same cycle.
module instr_enc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Zero when empty so the output reads 0 out of reset.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I encoder: one register stage that encodes/checks fields, then an output FIFO.
// Optional RV32I_INSTR_ENC_PC_EN tags each emitted word with a PC (out_pc).
module rv32i_instr_encoder
    import rv32i_instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef RV32I_INSTR_ENC_PC_EN
    , parameter logic [31:0] PC_RESET = 32'h1eceb000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_instr_encoder_if.slave bus
);
`ifdef RV32I_INSTR_ENC_PC_EN
    localparam int unsigned FW = 64;
`else
    localparam int unsigned FW = 32;
`endif

    enc_fmt_t    fmt;
    logic        enc_legal, variant_ok;
    instr_t      enc_word;
    logic [6:0]  funct7, op;
    logic [2:0]  f3;
    logic [31:0] imm;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_legal_q, s1_legal_d;
    instr_t      s1_word_q, s1_word_d;
    logic [15:0] err_count_q, err_count_d;
    logic        accept, s1_advance, drop, push;
    logic        fifo_in_ready;
    logic [FW-1:0] fifo_in_data, fifo_out_data;

    always_comb begin
        op      = bus.in_opcode;
        f3      = bus.in_funct3;
        imm     = bus.in_imm;
        funct7  = bus.in_variant ? FUNCT7_ALT : FUNCT7_BASE;
        fmt     = fmt_of(op, f3);
        enc_word  = '0;
        enc_legal = 1'b1;
        case (fmt)
            fmt_r:      enc_word = {funct7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, op};
            fmt_i: begin
                enc_legal = imm_fits(imm, IMM12_MIN, IMM12_MAX);
                enc_word  = {imm[11:0], bus.in_rs1, f3, bus.in_rd, op};
            end
            fmt_ishift: begin
                enc_legal = (imm[31:5] == '0);
                enc_word  = {funct7, imm[4:0], bus.in_rs1, f3, bus.in_rd, op};
            end
            fmt_s: begin
                enc_legal = imm_fits(imm, IMM12_MIN, IMM12_MAX);
                enc_word  = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], op};
            end
            fmt_b: begin
                enc_legal = imm_fits(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
                enc_word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11], op};
            end
            fmt_u: begin
                enc_legal = (imm[11:0] == '0);
                enc_word  = {imm[31:12], bus.in_rd, op};
            end
            fmt_j: begin
                enc_legal = imm_fits(imm, IMM21_MIN, IMM21_MAX) && !imm[0];
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
            end
            default:    enc_legal = 1'b0;
        endcase
        case (op)
            OP_LOAD:  if (f3 == 3'b011 || f3[2:1] == 2'b11) enc_legal = 1'b0;
            OP_STORE: if (f3 > 3'b010) enc_legal = 1'b0;
            OP_BR:    if (f3[2:1] == 2'b01) enc_legal = 1'b0;
            OP_JALR:  if (f3 != 3'b000) enc_legal = 1'b0;
            default:  ;
        endcase
        // Only add/sub, srl/sra and srli/srai have a funct7 alternate.
        variant_ok = (op == OP_REG && (f3 == 3'b000 || f3 == 3'b101)) ||
                     (op == OP_IMM && f3 == 3'b101);
        if (bus.in_variant && !variant_ok) enc_legal = 1'b0;
    end

    assign drop       = s1_valid_q && !s1_legal_q;
    assign push       = s1_valid_q && s1_legal_q && fifo_in_ready;
    assign s1_advance = drop || push;
    assign bus.in_ready = !s1_valid_q || s1_advance;
    assign accept     = bus.in_valid && bus.in_ready;
    assign bus.err    = drop;
    assign bus.err_count = err_count_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_legal_d  = s1_legal_q;
        s1_word_d   = s1_word_q;
        err_count_d = err_count_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_legal_d = enc_legal;
            s1_word_d  = enc_word;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
        if (drop && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_legal_q  <= 1'b0;
            s1_word_q   <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_legal_q  <= s1_legal_d;
            s1_word_q   <= s1_word_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef RV32I_INSTR_ENC_PC_EN
    // PC advances only on words actually entering the FIFO.
    logic [31:0] pc_q, pc_d;
    assign pc_d = push ? pc_q + 32'd4 : pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= PC_RESET;
        else        pc_q <= pc_d;
    end
    assign fifo_in_data = {pc_q, s1_word_q};
    assign bus.out_pc   = fifo_out_data[63:32];
`else
    assign fifo_in_data = s1_word_q;
`endif
    assign bus.out_instr = fifo_out_data[31:0];

    instr_enc_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_q && s1_legal_q),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (fifo_out_data)
    );

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the core's instruction decode: accepts decoded instruction fields (opcode, funct3, funct7 variant, rd/rs1/rs2, signed immediate) and produces legal 32-bit RV32I instruction words.
- Used in mp_verif to build directed and random instruction streams for the instruction-memory model.
- Two-part datapath: one register stage that encodes and checks legality, then an output FIFO, with valid/ready on both sides.
- Illegal field combinations are dropped and flagged; they are never emitted.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- PC_RESET, 32'h1eceb000, first PC tag (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  field bundle is valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_opcode  in  7  rv32i_opcode.
- in_funct3  in  3  funct3.
- in_variant  in  1  selects funct7 variant (0100000) when 1, base when 0.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte offset or immediate, not pre-shifted.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head.
- out_instr  out  32  encoded instruction word (instr_t).
- err  out  1  one-cycle pulse when an illegal bundle is dropped.
- err_count  out  16  count of illegal bundles, saturating.

Behaviour:
- Reset: out_valid=0, in_ready=1, err=0, err_count=0, stage invalid, FIFO empty, out_instr=0. Reset applies immediately, including mid-stream; in-flight data is discarded.
- Handshake: a transfer occurs on a cycle with valid&&ready. out_instr must be held stable while out_valid&&!out_ready.
- Stage 1 register captures the encoded word and a legal flag on accept.
  - Stage 1 advances when it holds a legal word and FIFO is not full (push), or when it holds an illegal word (drop).
  - in_ready = !s1_valid || s1_advance.
- FIFO push is not allowed while the FIFO is full, even if a pop happens in the same cycle. A pop and a push in the same cycle are allowed when the FIFO is not full.
- Latency: a bundle accepted at edge N is visible with out_valid at edge N+1 (FIFO empty, no stall). With continuous valid/ready, throughput is 1 per cycle. Order is strictly preserved.
- Encoding by opcode:
  - lui/auipc: imm[31:12].
  - jal: imm[20|10:1|11|19:12].
  - jalr/load/imm: imm[11:0].
  - imm with funct3 sll or sr: funct7 (from in_variant) goes in [31:25], imm[4:0] in [24:20].
  - store: imm[11:5] and imm[4:0] (S layout).
  - br: imm[12|10:5] and imm[4:1|11] (B layout).
  - reg: funct7, rs2, rs1.
- Fields not used by a format are forced to 0 (e.g. rs2 for I-type, rd for S/B).
- Illegal conditions:
  - Unknown opcode.
  - I/S immediate not representable in 12-bit signed.
  - B immediate not 13-bit signed, or imm[0]=1.
  - J immediate not 21-bit signed, or imm[0]=1.
  - U with imm[11:0] != 0.
  - Shift immediate not in 0..31.
  - Load funct3 in {011,110,111}; store funct3 > 010; branch funct3 in {010,011}; jalr funct3 != 000.
  - in_variant=1 other than on reg add/sr or imm sr.
- Illegal bundle: err pulses in the cycle after accept; err_count increments and saturates at 16'hFFFF.

Optional Feature:
- Macro: RV32I_INSTR_ENC_PC_EN.
- Defined: adds port out_pc (out, 32), carried alongside each FIFO entry.
  - The PC counter resets to PC_RESET and increments by 4 per legal push. Dropped bundles do not consume a PC.
- Undefined: no out_pc port and no PC storage.

Decomposition:
- Add to rv32i_types:
  - enc_fmt_t enum {fmt_r, fmt_i, fmt_ishift, fmt_s, fmt_b, fmt_u, fmt_j, fmt_bad}.
  - Immediate bound constants IMM12_MIN/MAX, IMM13_MIN/MAX, IMM21_MIN/MAX.
- Sub-module: instr_enc_fifo, a parameterised width/depth synchronous FIFO with valid/ready. The encoder instantiates it once; width is 32, or 64 when RV32I_INSTR_ENC_PC_EN is defined.

Test Plan:
- addi x1,x0,5 (imm,000,rd=1,rs1=0,imm=5), out_ready=1 → out_instr=32'h00500093 one cycle after accept, err=0.
- sub x3,x1,x2 (reg,000,variant=1) → 32'h402081B3. sw x5,-4(x2) → 32'hFE512E23.
- jal x1,+8 → 32'h008000EF. jal with imm=7 → dropped, err pulse, err_count=1, no output.
- addi imm=2048 and lw with funct3=011, sent back-to-back → both dropped, err_count=2, in_ready stays 1.
- out_ready=0 and DEPTH+2 legal bundles sent → FIFO fills; stage 1 holds one bundle; in_ready=0 with one bundle still waiting at the input. Then out_ready=1 → all DEPTH+2 words emerge in order, one per cycle.
- rst_n asserted low mid-stream with a full FIFO → out_valid=0 asynchronously, err_count=0. After release, the first new bundle is emitted normally; with the macro defined, out_pc=PC_RESET.
